lambo_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the Lambo processor. It fetches one instruction at a time and decodes its 3-bit opcode (CMP, BRANCH, LOAD, STORE, XOR, ADD, SUB, LSHIFT, encodings 000–111 from the `definitions` package). It then steps the datapath through execute, memory and write-back using one-cycle strobes and req/ack handshakes to instruction and data memory. It sits between the PC/instruction memory and the ALU/register file/data memory, and drives every datapath enable.

---
 rtl/lambo_ctrl_fsm.sv | 141 ++++++++++++++
 tb/tb_lambo_ctrl_fsm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lambo_ctrl_fsm.sv
// Multi-cycle control sequencer for the Lambo processor: fetch, decode, execute,
// memory and write-back sequencing with req/ack memory handshakes.
module lambo_ctrl_fsm #(
    parameter int unsigned INSTR_W = 9,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         opcode,
    output logic               alu_go,
    input  logic               cond_in,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               reg_we,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   retired
);

    localparam int unsigned OPC_W = 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_RETIRE = 3'd5;

    localparam logic [OPC_W-1:0] OP_BRANCH = 3'b001;
    localparam logic [OPC_W-1:0] OP_LOAD   = 3'b010;
    localparam logic [OPC_W-1:0] OP_STORE  = 3'b011;

    logic [2:0]         state, state_nxt;
    logic [INSTR_W-1:0] instr_nxt;
    logic [OPC_W-1:0]   op_nxt;
    logic               taken, taken_nxt;
    logic [CNT_W-1:0]   retired_nxt;
    logic               imem_req_nxt, alu_go_nxt, dmem_req_nxt, dmem_we_nxt;
    logic               reg_we_nxt, pc_inc_nxt, pc_load_nxt, busy_nxt, done_nxt;
    logic               load_target;

    assign opcode = instr[INSTR_W-1 -: OPC_W];

    // Next-state logic; outputs are decoded from the next state so they register
    // coincident with the state they belong to.
    always_comb begin
        state_nxt   = state;
        instr_nxt   = instr;
        taken_nxt   = taken;
        retired_nxt = retired;
        done_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_nxt = imem_data;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode == OP_BRANCH) taken_nxt = cond_in;
                if (opcode == OP_LOAD || opcode == OP_STORE) state_nxt = S_MEM;
                else if (opcode[2])                           state_nxt = S_WB;
                else                                          state_nxt = S_RETIRE;
            end
            S_MEM: begin
                if (dmem_ack) state_nxt = (opcode == OP_LOAD) ? S_WB : S_RETIRE;
            end
            S_WB: begin
                state_nxt = S_RETIRE;
            end
            S_RETIRE: begin
                if (retired != '1) retired_nxt = retired + CNT_W'(1);
                if (halt_req) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        op_nxt       = instr_nxt[INSTR_W-1 -: OPC_W];
        load_target  = (op_nxt == OP_BRANCH) && taken_nxt;
        imem_req_nxt = (state_nxt == S_FETCH);
        alu_go_nxt   = (state_nxt == S_EXEC);
        dmem_req_nxt = (state_nxt == S_MEM);
        dmem_we_nxt  = (state_nxt == S_MEM) && (op_nxt == OP_STORE);
        reg_we_nxt   = (state_nxt == S_WB);
        pc_load_nxt  = (state_nxt == S_RETIRE) && load_target;
        pc_inc_nxt   = (state_nxt == S_RETIRE) && !load_target;
        busy_nxt     = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            instr    <= '0;
            taken    <= 1'b0;
            retired  <= '0;
            imem_req <= 1'b0;
            alu_go   <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            reg_we   <= 1'b0;
            pc_inc   <= 1'b0;
            pc_load  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            instr    <= instr_nxt;
            taken    <= taken_nxt;
            retired  <= retired_nxt;
            imem_req <= imem_req_nxt;
            alu_go   <= alu_go_nxt;
            dmem_req <= dmem_req_nxt;
            dmem_we  <= dmem_we_nxt;
            reg_we   <= reg_we_nxt;
            pc_inc   <= pc_inc_nxt;
            pc_load  <= pc_load_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_lambo_ctrl_fsm.sv
// Bench for lambo_ctrl_fsm: instruction-level model builds the expected output
// vector for every cycle; a second instance with a 2-bit counter covers saturation.
module tb_lambo_ctrl_fsm;

    typedef struct packed {
        logic        imem_req;
        logic        alu_go;
        logic        dmem_req;
        logic        dmem_we;
        logic        reg_we;
        logic        pc_inc;
        logic        pc_load;
        logic        busy;
        logic        done;
        logic [8:0]  instr;
        logic [15:0] retired;
        logic [1:0]  retired2;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, halt_req = 1'b0;
    logic imem_ack = 1'b0, dmem_ack = 1'b0, cond_in = 1'b0;
    logic [8:0] imem_data = '0;

    logic imem_req, alu_go, dmem_req, dmem_we, reg_we, pc_inc, pc_load, busy, done;
    logic [8:0]  instr;
    logic [2:0]  opcode;
    logic [15:0] retired;

    logic s_imem_req, s_alu_go, s_dmem_req, s_dmem_we, s_reg_we, s_pc_inc, s_pc_load, s_busy, s_done;
    logic [8:0] s_instr;
    logic [2:0] s_opcode;
    logic [1:0] s_retired;

    lambo_ctrl_fsm #(.INSTR_W(9), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .opcode(opcode), .alu_go(alu_go), .cond_in(cond_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_we(reg_we), .pc_inc(pc_inc), .pc_load(pc_load),
        .busy(busy), .done(done), .retired(retired)
    );

    lambo_ctrl_fsm #(.INSTR_W(9), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .imem_req(s_imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(s_instr), .opcode(s_opcode), .alu_go(s_alu_go), .cond_in(cond_in),
        .dmem_req(s_dmem_req), .dmem_we(s_dmem_we), .dmem_ack(dmem_ack),
        .reg_we(s_reg_we), .pc_inc(s_pc_inc), .pc_load(s_pc_load),
        .busy(s_busy), .done(s_done), .retired(s_retired)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0, n_bad = 0;
    int   m_cnt = 0;
    logic [8:0] m_instr = '0;
    vec_t exp_v;
    bit   exp_on = 1'b0;

    int cyc = 0, t_fetch = 0, t_alu = 0, t_wb = 0, t_ret = 0;
    int n_alu = 0, n_dreq = 0, n_dwe = 0, n_rwe = 0, n_pci = 0, n_pcl = 0;
    logic prev_ireq = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic vec_t base();
        vec_t e;
        e          = '0;
        e.instr    = m_instr;
        e.retired  = 16'(m_cnt);
        e.retired2 = (m_cnt >= 3) ? 2'd3 : 2'(m_cnt);
        return e;
    endfunction

    // Per-cycle compare against the model plus per-instruction event statistics.
    always @(negedge clk) begin
        vec_t act;
        bit   rise;
        cyc  <= cyc + 1;
        rise = imem_req && !prev_ireq;
        if (rise) t_fetch <= cyc;
        if (alu_go) t_alu <= cyc;
        if (reg_we) t_wb <= cyc;
        if (pc_inc || pc_load) t_ret <= cyc;
        n_alu  <= (rise ? 0 : n_alu)  + int'(alu_go);
        n_dreq <= (rise ? 0 : n_dreq) + int'(dmem_req);
        n_dwe  <= (rise ? 0 : n_dwe)  + int'(dmem_we);
        n_rwe  <= (rise ? 0 : n_rwe)  + int'(reg_we);
        n_pci  <= (rise ? 0 : n_pci)  + int'(pc_inc);
        n_pcl  <= (rise ? 0 : n_pcl)  + int'(pc_load);
        prev_ireq <= imem_req;
        if (exp_on) begin
            act.imem_req = imem_req; act.alu_go = alu_go; act.dmem_req = dmem_req;
            act.dmem_we  = dmem_we;  act.reg_we = reg_we; act.pc_inc = pc_inc;
            act.pc_load  = pc_load;  act.busy   = busy;   act.done   = done;
            act.instr    = instr;    act.retired = retired; act.retired2 = s_retired;
            chk("outputs", 64'(act), 64'(exp_v));
            chk("opcode", 64'(opcode), 64'(exp_v.instr[8:6]));
        end
    end

    task automatic adv(input bit noise);
        @(posedge clk); #1;
        start     = noise;
        imem_ack  = noise;
        dmem_ack  = noise;
        cond_in   = noise;
        halt_req  = 1'b0;
        imem_data = 9'h1ff;
    endtask

    task automatic idle(input int n, input bit ackn);
        for (int i = 0; i < n; i++) begin
            adv(1'b0);
            imem_ack  = ackn;
            dmem_ack  = ackn;
            imem_data = 9'h0ab;
            exp_v     = base();
        end
    endtask

    // hm: 0 no halt, 1 halt_req from after EXEC, 2 halt_req held throughout.
    task automatic run(input logic [8:0] d, input int iw, input int dw, input logic c,
                       input bit from_idle, input int hm, input bit noise);
        logic [2:0] op;
        bit   is_mem, is_wb, br;
        vec_t e;
        op     = d[8:6];
        is_mem = (op == 3'b010) || (op == 3'b011);
        is_wb  = (op == 3'b010) || op[2];
        br     = (op == 3'b001) && c;
        if (from_idle) begin
            adv(noise); start = 1'b1; halt_req = (hm == 2);
            exp_v = base();
        end
        for (int i = 0; i <= iw; i++) begin
            adv(noise); halt_req = (hm == 2);
            imem_ack  = (i == iw);
            imem_data = (i == iw) ? d : ~d;
            e = base(); e.imem_req = 1'b1; e.busy = 1'b1; exp_v = e;
        end
        m_instr = d;
        adv(noise); halt_req = (hm == 2); cond_in = c;
        e = base(); e.alu_go = 1'b1; e.busy = 1'b1; exp_v = e;
        if (is_mem) begin
            for (int j = 0; j <= dw; j++) begin
                adv(noise); halt_req = (hm != 0);
                dmem_ack = (j == dw);
                e = base(); e.dmem_req = 1'b1; e.dmem_we = (op == 3'b011); e.busy = 1'b1; exp_v = e;
            end
        end
        if (is_wb) begin
            adv(noise); halt_req = (hm != 0);
            e = base(); e.reg_we = 1'b1; e.busy = 1'b1; exp_v = e;
        end
        adv(noise); halt_req = (hm != 0);
        e = base(); e.pc_load = br; e.pc_inc = !br; e.busy = 1'b1; exp_v = e;
        m_cnt++;
        if (hm != 0) begin
            adv(noise); start = 1'b0;
            e = base(); e.done = 1'b1; exp_v = e;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        exp_v = base(); exp_on = 1'b1;
        adv(1'b0); exp_v = base();
        adv(1'b0); rst_n = 1'b1; exp_v = base();
        idle(2, 1'b0);

        // ADD, zero-wait
        run(9'b101_000000, 0, 0, 1'b0, 1'b1, 1, 1'b0);
        chk("add_alu_cyc", 64'(t_alu - t_fetch), 64'd1);
        chk("add_wb_cyc", 64'(t_wb - t_fetch), 64'd2);
        chk("add_inc_cyc", 64'(t_ret - t_fetch), 64'd3);
        chk("add_dmem_req", 64'(n_dreq), 64'd0);
        chk("add_retired", 64'(retired), 64'd1);
        chk("add_done", 64'(done), 64'd1);

        // LOAD, dmem ack after 3 waits, halt raised mid-instruction
        run(9'b010_001100, 0, 3, 1'b0, 1'b1, 1, 1'b0);
        chk("load_dreq_len", 64'(n_dreq), 64'd4);
        chk("load_dwe", 64'(n_dwe), 64'd0);
        chk("load_total", 64'(t_ret - t_fetch + 1), 64'd8);
        chk("load_wb_before_ret", 64'(t_ret - t_wb), 64'd1);
        chk("load_busy", 64'(busy), 64'd0);
        chk("load_retired", 64'(retired), 64'd2);
        idle(3, 1'b1);
        chk("ack_ignored_instr", 64'(instr), 64'h08c);

        run(9'b001_010101, 1, 0, 1'b1, 1'b1, 1, 1'b1);
        chk("br_t_pcl", 64'(n_pcl), 64'd1);
        chk("br_t_pci", 64'(n_pci), 64'd0);
        chk("br_t_rwe", 64'(n_rwe), 64'd0);
        run(9'b001_101010, 0, 0, 1'b0, 1'b1, 1, 1'b1);
        chk("br_n_pci", 64'(n_pci), 64'd1);
        chk("br_n_pcl", 64'(n_pcl), 64'd0);
        chk("br_n_rwe", 64'(n_rwe), 64'd0);

        run(9'b011_000011, 0, 1, 1'b0, 1'b1, 1, 1'b1);
        chk("st_dreq", 64'(n_dreq), 64'd2);
        chk("st_dwe", 64'(n_dwe), 64'd2);
        chk("st_rwe", 64'(n_rwe), 64'd0);
        run(9'b000_111000, 0, 0, 1'b1, 1'b1, 1, 1'b0);
        chk("cmp_alu", 64'(n_alu), 64'd1);
        chk("cmp_dreq", 64'(n_dreq), 64'd0);
        chk("cmp_rwe", 64'(n_rwe), 64'd0);
        chk("cmp_len", 64'(t_ret - t_fetch + 1), 64'd3);
        chk("sat_retired", 64'(s_retired), 64'd3);

        // back-to-back chain, then start+halt together
        run(9'b110_000001, 2, 0, 1'b0, 1'b1, 0, 1'b1);
        run(9'b100_000010, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        run(9'b111_000100, 1, 0, 1'b0, 1'b0, 1, 1'b1);
        run(9'b101_110011, 0, 0, 1'b0, 1'b1, 2, 1'b0);
        chk("halt_start_retired", 64'(retired), 64'd10);
        chk("halt_start_done", 64'(done), 64'd1);
        idle(1, 1'b0);

        // async reset while in MEM
        adv(1'b0); start = 1'b1; exp_v = base();
        adv(1'b0); imem_ack = 1'b1; imem_data = 9'b010_000111;
        exp_v = base(); exp_v.imem_req = 1'b1; exp_v.busy = 1'b1;
        m_instr = 9'b010_000111;
        adv(1'b0); exp_v = base(); exp_v.alu_go = 1'b1; exp_v.busy = 1'b1;
        adv(1'b0); exp_v = base(); exp_v.dmem_req = 1'b1; exp_v.busy = 1'b1;
        #3 rst_n = 1'b0; exp_on = 1'b0;
        #1;
        chk("mrst_dmem_req", 64'(dmem_req), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_instr", 64'(instr), 64'd0);
        chk("mrst_opcode", 64'(opcode), 64'd0);
        chk("mrst_retired", 64'(retired), 64'd0);
        m_instr = '0; m_cnt = 0;
        exp_v = base(); exp_on = 1'b1;
        adv(1'b0); exp_v = base();
        adv(1'b0); rst_n = 1'b1; exp_v = base();
        idle(3, 1'b0);
        chk("post_rst_idle", 64'(busy), 64'd0);
        run(9'b000_000001, 0, 0, 1'b0, 1'b1, 1, 1'b0);
        chk("post_rst_retired", 64'(retired), 64'd1);
        idle(2, 1'b0);

        exp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
